// File: rtl/bcd_stopwatch_pkg.sv
// Shared constants for the BCD stopwatch: digit width, digit ceiling, direction codes.
// Pure declarations, no timing; no flow control involved.
// The digit clamp helper is shared by the top-level preset path.
package bcd_stopwatch_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic       DIR_UP   = 1'b0;
    localparam logic       DIR_DOWN = 1'b1;

    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_digit.sv
// One BCD digit of the up/down ripple chain: step the digit when ci is set.
// Purely combinational, zero latency.
// No backpressure; co is the carry (up) or borrow (down) into the next digit.
module bcd_digit_updown
    import bcd_stopwatch_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             ci,
    input  logic             dir,
    output logic [BCD_W-1:0] next_digit,
    output logic             co
);

    always_comb begin
        next_digit = digit;
        co         = 1'b0;
        if (ci) begin
            if (dir == DIR_UP) begin
                if (digit >= BCD_MAX) begin
                    next_digit = '0;
                    co         = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end else begin
                if (digit == '0) begin
                    next_digit = BCD_MAX;
                    co         = 1'b1;
                end else begin
                    next_digit = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// Prescaled BCD up/down stopwatch with preset, wrap pulse and sticky expiry (lap capture with BCD_STOPWATCH_LAP_EN).
// Count updates on the prescaler terminal edge; tick_out/wrap follow with one cycle latency.
// No backpressure: count_enabled low freezes prescaler and count, load acts at any time.
module bcd_stopwatch
    import bcd_stopwatch_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int TICK_HZ  = 1,
    parameter int DIGITS   = 4
) (
    input  logic                    clk,
    input  logic                    init_regs,
    input  logic                    count_enabled,
    input  logic                    dir,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_value,
`ifdef BCD_STOPWATCH_LAP_EN
    input  logic                    lap,
    output logic [BCD_W*DIGITS-1:0] lap_reading,
`endif
    output logic [BCD_W*DIGITS-1:0] time_reading,
    output logic                    tick_out,
    output logic                    wrap,
    output logic                    expired
);

    localparam int PRESCALE = CLK_FREQ / TICK_HZ;
    localparam int PRE_W    = $clog2(PRESCALE);
    localparam int CNT_W    = BCD_W * DIGITS;

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic [DIGITS:0]  carry;
    logic [CNT_W-1:0] next_count;
    logic [CNT_W-1:0] load_clamped;
    logic             hold_zero;
    logic             advance;

    assign tick      = count_enabled && (pre == PRE_W'(PRESCALE - 1));
    // A down-count parked at zero swallows the tick entirely, including tick_out.
    assign hold_zero = (dir == DIR_DOWN) && (time_reading == '0);
    assign advance   = tick && !hold_zero;
    assign carry[0]  = 1'b1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_updown u_digit (
                .digit      (time_reading[g*BCD_W +: BCD_W]),
                .ci         (carry[g]),
                .dir        (dir),
                .next_digit (next_count[g*BCD_W +: BCD_W]),
                .co         (carry[g+1])
            );
        end
    endgenerate

    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[i*BCD_W +: BCD_W] = clamp_digit(load_value[i*BCD_W +: BCD_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (init_regs) begin
            pre          <= '0;
            time_reading <= '0;
            tick_out     <= 1'b0;
            wrap         <= 1'b0;
            expired      <= 1'b0;
        end else if (load) begin
            pre          <= '0;
            time_reading <= load_clamped;
            tick_out     <= 1'b0;
            wrap         <= 1'b0;
            expired      <= 1'b0;
        end else begin
            tick_out <= advance;
            wrap     <= advance && (dir == DIR_UP) && carry[DIGITS];
            if (count_enabled) begin
                pre <= tick ? '0 : pre + PRE_W'(1);
            end
            if (advance) begin
                time_reading <= next_count;
            end
            if (advance && (dir == DIR_DOWN) && (next_count == '0)) begin
                expired <= 1'b1;
            end
        end
    end

`ifdef BCD_STOPWATCH_LAP_EN
    always_ff @(posedge clk) begin
        if (init_regs) begin
            lap_reading <= '0;
        end else if (lap) begin
            lap_reading <= time_reading;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Randomized plus directed bench for bcd_stopwatch against an integer-valued reference model.
module tb_bcd_stopwatch;

    localparam int CLK_FREQ = 10;
    localparam int TICK_HZ  = 1;
    localparam int DIGITS   = 2;
    localparam int W        = 4 * DIGITS;
    localparam int PRESCALE = CLK_FREQ / TICK_HZ;
    localparam int MAXV     = 10 ** DIGITS - 1;

    logic         clk = 1'b0;
    logic         init_regs = 1'b1;
    logic         count_enabled = 1'b0;
    logic         dir = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] time_reading;
    logic         tick_out;
    logic         wrap;
    logic         expired;
`ifdef BCD_STOPWATCH_LAP_EN
    logic         lap = 1'b0;
    logic [W-1:0] lap_reading;
    int           m_lap;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: decimal count value, prescale phase, pulse and flag expectations.
    int m_val, m_pre;
    bit m_tick, m_wrap, m_exp;

    bcd_stopwatch #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ), .DIGITS(DIGITS)) dut (
        .clk           (clk),
        .init_regs     (init_regs),
        .count_enabled (count_enabled),
        .dir           (dir),
        .load          (load),
        .load_value    (load_value),
`ifdef BCD_STOPWATCH_LAP_EN
        .lap           (lap),
        .lap_reading   (lap_reading),
`endif
        .time_reading  (time_reading),
        .tick_out      (tick_out),
        .wrap          (wrap),
        .expired       (expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd_clamped(input logic [W-1:0] b);
        int v;
        int d;
        v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(b[i*4 +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    task automatic model_update();
        if (init_regs) begin
            m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0; m_exp = 0;
`ifdef BCD_STOPWATCH_LAP_EN
            m_lap = 0;
`endif
            return;
        end
`ifdef BCD_STOPWATCH_LAP_EN
        if (lap) m_lap = m_val;
`endif
        m_tick = 0;
        m_wrap = 0;
        if (load) begin
            m_val = from_bcd_clamped(load_value);
            m_pre = 0;
            m_exp = 0;
        end else if (count_enabled) begin
            if (m_pre == PRESCALE - 1) begin
                m_pre = 0;
                if (!dir) begin
                    m_wrap = (m_val == MAXV);
                    m_val  = (m_val + 1) % (MAXV + 1);
                    m_tick = 1;
                end else if (m_val > 0) begin
                    m_val  = m_val - 1;
                    m_tick = 1;
                    if (m_val == 0) m_exp = 1;
                end
            end else begin
                m_pre = m_pre + 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
        check("time_reading", 32'(time_reading), 32'(to_bcd(m_val)));
        check("tick_out", 32'(tick_out), 32'(m_tick));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("expired", 32'(expired), 32'(m_exp));
`ifdef BCD_STOPWATCH_LAP_EN
        check("lap_reading", 32'(lap_reading), 32'(to_bcd(m_lap)));
`endif
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1;
        load_value = v;
        cyc();
        load = 1'b0;
    endtask

    task automatic run_to_tick_edge();
        int guard;
        guard = 0;
        while (m_pre != PRESCALE - 1 && guard < 4 * PRESCALE) begin
            cyc();
            guard++;
        end
        check("tick_edge_reached", 32'(m_pre), 32'(PRESCALE - 1));
    endtask

    initial begin
        int cnt;

        m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0; m_exp = 0;
`ifdef BCD_STOPWATCH_LAP_EN
        m_lap = 0;
`endif
        // Reset, then count up from zero.
        repeat (2) cyc();
        init_regs = 1'b0;
        count_enabled = 1'b1;
        dir = 1'b0;
        repeat (10) cyc();
        check("first_tick_time", 32'(time_reading), 32'h01);
        check("first_tick_pulse", 32'(tick_out), 32'h1);
        repeat (10) cyc();
        check("second_tick_time", 32'(time_reading), 32'h02);
        check("second_tick_pulse", 32'(tick_out), 32'h1);

        // Roll over from all nines.
        do_load(8'h98);
        cnt = 0;
        repeat (20) begin
            cyc();
            if (wrap) cnt++;
        end
        check("wrap_value", 32'(time_reading), 32'h00);
        check("wrap_count", 32'(cnt), 32'd1);
        check("wrap_no_expire", 32'(expired), 32'h0);

        // Count down to zero and park there.
        dir = 1'b1;
        do_load(8'h10);
        repeat (100) cyc();
        check("down_zero", 32'(time_reading), 32'h00);
        check("down_expired", 32'(expired), 32'h1);
        cnt = 0;
        repeat (30) begin
            cyc();
            if (tick_out) cnt++;
        end
        check("park_ticks", 32'(cnt), 32'd0);
        check("park_value", 32'(time_reading), 32'h00);
        dir = 1'b0;
        repeat (25) cyc();
        check("expired_sticky_up", 32'(expired), 32'h1);

        // Digit clamp and load-over-tick.
        do_load(8'hA5);
        check("clamp_load", 32'(time_reading), 32'h95);
        check("load_clears_expired", 32'(expired), 32'h0);
        run_to_tick_edge();
        do_load(8'h37);
        check("load_beats_tick", 32'(time_reading), 32'h37);
        check("load_tick_pulse", 32'(tick_out), 32'h0);

        // Enable pause stretches the prescale by exactly the pause length.
        do_load(8'h20);
        repeat (4) cyc();
        count_enabled = 1'b0;
        repeat (7) cyc();
        count_enabled = 1'b1;
        cnt = 0;
        while (!tick_out && cnt < 40) begin
            cyc();
            cnt++;
        end
        check("pause_delay", 32'(cnt + 11), 32'd17);
        check("pause_value", 32'(time_reading), 32'h21);

        // Reset mid-count.
        repeat (3) cyc();
        init_regs = 1'b1;
        cyc();
        check("reset_time", 32'(time_reading), 32'h0);
        check("reset_expired", 32'(expired), 32'h0);
        init_regs = 1'b0;

`ifdef BCD_STOPWATCH_LAP_EN
        do_load(8'h41);
        run_to_tick_edge();
        lap = 1'b1;
        cyc();
        lap = 1'b0;
        check("lap_capture", 32'(lap_reading), 32'h41);
        check("lap_time", 32'(time_reading), 32'h42);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            init_regs     = ($urandom_range(0, 199) == 0);
            load          = ($urandom_range(0, 39) == 0);
            load_value    = W'($urandom);
            count_enabled = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 59) == 0) dir = ~dir;
`ifdef BCD_STOPWATCH_LAP_EN
            lap = ($urandom_range(0, 9) == 0);
`endif
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch.md
BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, count rate in Hz; PRESCALE = CLK_FREQ/TICK_HZ, which SHALL be >= 2.
REQ-003 Parameter DIGITS, default 4, number of BCD digits; legal range 1..8.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 init_regs  input  1  reset, synchronous, active-high.
REQ-006 count_enabled  input  1  high = prescaler and counter advance; low = all state frozen.
REQ-007 dir  input  1  0 = count up, 1 = count down.
REQ-008 load  input  1  single-cycle request to preset the counter.
REQ-009 load_value  input  4*DIGITS  BCD preset; digit 0 in bits [3:0].
REQ-010 time_reading  output  4*DIGITS  registered BCD count; digit 0 least significant.
REQ-011 tick_out  output  1  one-cycle pulse on each cycle where the count updates.
REQ-012 wrap  output  1  one-cycle pulse when an up-count rolls from all-9s to all-0s.
REQ-013 expired  output  1  sticky flag; down-count has reached zero.

Function
REQ-014 Priority per cycle SHALL be: init_regs, then load, then counting.
REQ-015 Prescaler SHALL count 0..PRESCALE-1 while count_enabled=1, and hold otherwise.
REQ-016 Internal tick SHALL be asserted in the cycle where the prescaler equals PRESCALE-1 and count_enabled=1; the prescaler then returns to 0.
REQ-017 On tick with dir=0, the count SHALL increment by one in BCD, with carry rippling digit 0 to digit DIGITS-1 in the same cycle.
REQ-018 Up-count at all-9s SHALL become all-0s, with wrap=1 for exactly that cycle.
REQ-019 On tick with dir=1 and a nonzero count, the count SHALL decrement by one in BCD, with digits borrowing 0 to 9.
REQ-020 When a decrement produces all-0s, expired SHALL become 1 on the same edge.
REQ-021 On tick with dir=1 and count already all-0s, the count SHALL hold at zero (no underflow); tick_out SHALL NOT pulse.
REQ-022 tick_out SHALL be registered, pulsing in the cycle after the edge that updated time_reading (latency 1).
REQ-023 wrap SHALL be registered with the same timing as tick_out.
REQ-024 load=1 SHALL copy load_value into the count, clear the prescaler and clear expired; any load digit >9 SHALL be stored as 9.
REQ-025 load SHALL act regardless of count_enabled.
REQ-026 load and a tick in the same cycle: the load wins and the tick is discarded.
REQ-027 A change of dir SHALL take effect at the next tick; the prescaler SHALL NOT be cleared by a dir change.
REQ-028 expired SHALL clear only on init_regs or load, and SHALL remain set during subsequent up-counting.

Reset
REQ-029 init_regs=1 SHALL clear on the next edge: the prescaler, time_reading, tick_out, wrap, expired, and lap_reading when present.
REQ-030 Reset asserted mid-count SHALL discard the pending tick and any partial prescale.

Configuration
REQ-031 With macro BCD_STOPWATCH_LAP_EN defined, the module SHALL add:
- input lap (1 bit)
- output lap_reading (4*DIGITS bits)
REQ-032 With BCD_STOPWATCH_LAP_EN, lap=1 SHALL capture the pre-edge time_reading into lap_reading, including during a tick cycle; lap_reading SHALL otherwise hold.
REQ-033 Without the macro, lap and lap_reading SHALL be absent and no capture register SHALL be synthesised.

Structure
REQ-034 A shared package SHALL hold:
- the BCD digit width constant (4)
- the max-digit constant (9)
- the up/down direction encodings
REQ-035 One sub-module, bcd_digit_updown, SHALL implement a single digit with inputs digit, ci, dir and outputs next_digit, co. The top SHALL instantiate it DIGITS times via generate.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- CLK_FREQ=10, TICK_HZ=1, DIGITS=2, dir=0, enable from reset -> time_reading goes 0x00 to 0x01 after 10 cycles, tick_out pulses every 10 cycles.
- Load 0x98 then count up 2 ticks -> 0x99 then 0x00, wrap pulses once, expired stays 0.
- Load 0x10, dir=1, 10 ticks -> 0x09 ... 0x00, expired=1, and time_reading stays 0x00 over further ticks with no tick_out.
- Load 0xA5 -> time_reading=0x95; load asserted on a tick cycle -> loaded value, no increment.
- count_enabled low for 7 cycles mid-prescale -> next tick delayed by exactly 7 cycles; init_regs mid-count -> all outputs 0 next cycle.
- BCD_STOPWATCH_LAP_EN: lap on a tick cycle at 0x41 -> lap_reading=0x41 while time_reading=0x42.
